// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake, optional 2-entry skid
// buffer, flush, global stall/enable gating and a stall-cycle counter.
module pipe_stage_elastic #(
  parameter int                DATA_W   = 32,
  parameter int                STALL_W  = 6,
  parameter int                STAGE    = 3,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter bit                SKID_EN  = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic               flush_in,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [1:0]         occupancy,
  output logic [31:0]        stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t              state_p0, state_d;
  logic [DATA_W-1:0]   main_p0, main_d;
  logic [DATA_W-1:0]   skid_p0, skid_d;
  logic [31:0]         cnt_p0;
  logic                vld_p0;
  logic                stall_up, stall_dn;
  logic                in_fire, out_fire;
  logic                stall_unused;

  // Only our own and the downstream stall bit matter; the rest are folded away.
  assign stall_unused = ^stall_in;
  assign stall_up     = stall_in[STAGE];
  assign stall_dn     = stall_in[STAGE+1];

  assign vld_p0   = (state_p0 != EMPTY);
  assign in_fire  = in_valid & in_ready & ~stall_up;
  assign out_fire = vld_p0 & out_ready & ~stall_dn;

  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = (state_p0 != SKID);
    end else begin : g_pass
      // Pass-through ready: a full stage accepts only while it drains.
      assign in_ready = (state_p0 == EMPTY) | out_fire;
    end
  endgenerate

  always_comb begin
    state_d = state_p0;
    main_d  = main_p0;
    skid_d  = skid_p0;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = EMPTY;
        main_d  = NOP_DATA;
        skid_d  = NOP_DATA;
      end else begin
        case (state_p0)
          EMPTY: begin
            if (in_fire) begin
              state_d = FULL;
              main_d  = in_data;
            end
          end
          FULL: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              state_d = SKID;
              skid_d  = in_data;
            end else if (out_fire) begin
              state_d = EMPTY;
              main_d  = NOP_DATA;
            end
          end
          SKID: begin
            if (out_fire) begin
              state_d = FULL;
              main_d  = skid_p0;
              skid_d  = NOP_DATA;
            end
          end
          default: begin
            state_d = EMPTY;
            main_d  = NOP_DATA;
          end
        endcase
      end
    end
  end

  // Stage p0: control state and the visible main payload reset asynchronously.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_p0 <= EMPTY;
      main_p0  <= NOP_DATA;
      cnt_p0   <= 32'd0;
    end else begin
      state_p0 <= state_d;
      main_p0  <= main_d;
      if (rdy_in && vld_p0 && !out_fire)
        cnt_p0 <= cnt_p0 + 32'd1;
    end
  end

  // Skid payload is only read after it has been written, so it needs no reset.
  always_ff @(posedge clk_in) begin
    skid_p0 <= skid_d;
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_p0)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_valid    = vld_p0;
  assign out_data     = main_p0;
  assign stall_cycles = cnt_p0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: one skid-enabled and one pass-through
// instance, with a per-instance scoreboard of expected output payloads.
module tb_pipe_stage_elastic;

  localparam logic [31:0] NOP = 32'hDEAD_BEEF;
  localparam logic [5:0]  ST_UP = 6'b001000;
  localparam logic [5:0]  ST_DN = 6'b010000;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [5:0]  stall;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data, a_stall_cycles;
  logic [1:0]  a_occ;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data, b_stall_cycles;
  logic [1:0]  b_occ;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(32), .STALL_W(6), .STAGE(3), .NOP_DATA(NOP), .SKID_EN(1'b1)) dut_a (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .stall_in(stall), .flush_in(flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .occupancy(a_occ), .stall_cycles(a_stall_cycles)
  );

  pipe_stage_elastic #(.DATA_W(32), .STALL_W(6), .STAGE(3), .NOP_DATA(NOP), .SKID_EN(1'b0)) dut_b (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .stall_in(stall), .flush_in(flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .occupancy(b_occ), .stall_cycles(b_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare any output transfer seen just before the coming edge, then advance.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (rdy && !flush && a_out_valid && a_out_ready && !stall[4]) begin
      if (q_a.size() == 0) chk("a_unexpected_out", a_out_data, NOP);
      else begin e = q_a.pop_front(); chk("a_out_data", a_out_data, e); end
    end
    if (rdy && !flush && b_out_valid && b_out_ready && !stall[4]) begin
      if (q_b.size() == 0) chk("b_unexpected_out", b_out_data, NOP);
      else begin e = q_b.pop_front(); chk("b_out_data", b_out_data, e); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic ordy);
    a_in_valid = v; a_in_data = d; a_out_ready = ordy;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic ordy);
    b_in_valid = v; b_in_data = d; b_out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = '0;
    drive_a(1'b0, 32'h0, 1'b1);
    drive_b(1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_out_data", a_out_data, NOP);
    chk("rst_a_occ", {30'd0, a_occ}, 32'd0);
    chk("rst_a_stall_cycles", a_stall_cycles, 32'd0);
    chk("rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_b_out_data", b_out_data, NOP);
    chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
    rst = 1'b0;

    // Streaming: one payload per cycle, first visible one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 32'h11 + i, 1'b1);
      q_a.push_back(32'h11 + i);
      tick();
      chk("stream_a_valid", {31'd0, a_out_valid}, 32'd1);
      chk("stream_a_data", a_out_data, 32'h11 + i);
    end
    drive_a(1'b0, 32'h0, 1'b1);
    tick();
    chk("stream_a_drained_valid", {31'd0, a_out_valid}, 32'd0);
    chk("stream_a_drained_data", a_out_data, NOP);
    chk("stream_a_no_stall", a_stall_cycles, 32'd0);

    // Skid fill with downstream not ready.
    drive_a(1'b1, 32'h21, 1'b0); q_a.push_back(32'h21); tick();
    drive_a(1'b1, 32'h22, 1'b0); q_a.push_back(32'h22); tick();
    chk("skid_occ", {30'd0, a_occ}, 32'd2);
    chk("skid_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("skid_main", a_out_data, 32'h21);
    drive_a(1'b1, 32'h23, 1'b0); tick(); tick();
    chk("skid_hold_occ", {30'd0, a_occ}, 32'd2);
    chk("skid_stall_cycles", a_stall_cycles, 32'd3);
    drive_a(1'b0, 32'h0, 1'b1); tick();
    chk("skid_to_full_occ", {30'd0, a_occ}, 32'd1);
    chk("skid_to_full_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("skid_to_full_data", a_out_data, 32'h22);
    chk("skid_drain_stall_cycles", a_stall_cycles, 32'd3);
    tick();
    chk("skid_empty_occ", {30'd0, a_occ}, 32'd0);

    // Bubble: upstream stalled while downstream drains.
    drive_a(1'b1, 32'h31, 1'b0); q_a.push_back(32'h31); tick();
    stall = ST_UP;
    drive_a(1'b1, 32'h32, 1'b1); tick();
    chk("bubble_valid", {31'd0, a_out_valid}, 32'd0);
    chk("bubble_data", a_out_data, NOP);
    chk("bubble_occ", {30'd0, a_occ}, 32'd0);
    stall = '0;

    // Downstream stall holds main while the skid slot fills.
    drive_a(1'b1, 32'h41, 1'b1); q_a.push_back(32'h41); tick();
    stall = ST_DN;
    drive_a(1'b1, 32'h42, 1'b1); q_a.push_back(32'h42); tick();
    chk("dnstall_occ", {30'd0, a_occ}, 32'd2);
    chk("dnstall_data", a_out_data, 32'h41);
    chk("dnstall_stall_cycles", a_stall_cycles, 32'd4);
    stall = '0;

    // Flush from SKID drops both entries and the incoming payload.
    q_a.delete();
    flush = 1'b1;
    drive_a(1'b1, 32'h43, 1'b0); tick();
    chk("flush_occ", {30'd0, a_occ}, 32'd0);
    chk("flush_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush_data", a_out_data, NOP);
    chk("flush_keeps_counter", a_stall_cycles, 32'd5);
    flush = 1'b0;
    drive_a(1'b0, 32'h0, 1'b1); tick();
    chk("flush_c_discarded", {31'd0, a_out_valid}, 32'd0);

    // Global enable low freezes everything.
    drive_a(1'b1, 32'h51, 1'b0); q_a.push_back(32'h51); tick();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      flush = i[0];
      drive_a(1'b1, 32'h60 + i, ~i[0]);
      tick();
      chk("frozen_valid", {31'd0, a_out_valid}, 32'd1);
      chk("frozen_data", a_out_data, 32'h51);
      chk("frozen_occ", {30'd0, a_occ}, 32'd1);
      chk("frozen_stall_cycles", a_stall_cycles, 32'd5);
    end
    rdy = 1'b1; flush = 1'b0;
    drive_a(1'b0, 32'h0, 1'b1); tick();
    chk("unfrozen_drain_occ", {30'd0, a_occ}, 32'd0);

    // Pass-through instance: streaming, then combinational ready.
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 32'h81 + i, 1'b1);
      q_b.push_back(32'h81 + i);
      tick();
      chk("stream_b_valid", {31'd0, b_out_valid}, 32'd1);
    end
    drive_b(1'b1, 32'h72, 1'b0);
    #1;
    chk("b_ready_falls_comb", {31'd0, b_in_ready}, 32'd0);
    tick();
    chk("b_hold_data", b_out_data, 32'h84);
    chk("b_hold_occ", {30'd0, b_occ}, 32'd1);
    drive_b(1'b1, 32'h72, 1'b1);
    #1;
    chk("b_ready_rises_comb", {31'd0, b_in_ready}, 32'd1);
    q_b.push_back(32'h72);
    tick();
    chk("b_swap_data", b_out_data, 32'h72);
    chk("b_swap_valid", {31'd0, b_out_valid}, 32'd1);
    drive_b(1'b0, 32'h0, 1'b1); tick();
    chk("b_empty_occ", {30'd0, b_occ}, 32'd0);
    chk("b_stall_cycles", b_stall_cycles, 32'd1);

    // Asynchronous reset in mid-cycle while holding a payload.
    drive_a(1'b1, 32'h91, 1'b0); tick();
    drive_a(1'b0, 32'h0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("async_rst_data", a_out_data, NOP);
    chk("async_rst_counter", a_stall_cycles, 32'd0);
    chk("async_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    rst = 1'b0;
    drive_a(1'b1, 32'h92, 1'b1); q_a.push_back(32'h92); tick();
    chk("post_rst_valid", {31'd0, a_out_valid}, 32'd1);
    chk("post_rst_data", a_out_data, 32'h92);
    drive_a(1'b0, 32'h0, 1'b1); tick();

    chk("a_scoreboard_empty", q_a.size(), 32'd0);
    chk("b_scoreboard_empty", q_b.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
